// File: rtl/z_pkg.sv
// Shared fetch/controller definitions: FSM encoding, word width, alignment helper.
package z_pkg;

  localparam int WORD_W = 32;

  // Low address bits that must be zero for a word-aligned instruction address.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  // True when an instruction address is not on a word boundary.
  function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
    return (addr[1:0] & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/z_fetch_timer.sv
// 8-bit clear/enable wait counter for the fetch request phase.
// expired flags the enabled cycle whose increment brings the count up to
// TIMEOUT, so the owner leaves REQ after exactly TIMEOUT unacknowledged cycles.
module z_fetch_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] count_q;

  // Wait counter: clear has priority over increment.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else if (clr) begin
      count_q <= 8'd0;
    end else if (en) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign expired = en && ((count_q + 8'd1) == LIMIT);

endmodule

// File: rtl/z_fetch.sv
// Instruction fetch unit: req/ack toward instruction memory, valid/ready toward
// the controller, with flush redirect, misalignment and timeout faults.
// Every output is a flop or a decode of the state register.
module z_fetch
  import z_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned       TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] inst,
  output logic [WORD_W-1:0] pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic [WORD_W-1:0] next_pc,
  input  logic              flush,
  input  logic [WORD_W-1:0] flush_pc,
  output logic              fault,
  output logic [15:0]       fetch_count
);

  fetch_state_t      state_q;
  fetch_state_t      state_next;
  logic [WORD_W-1:0] fetch_addr_q;
  logic [WORD_W-1:0] inst_q;
  logic [WORD_W-1:0] pc_q;
  logic [15:0]       count_q;

  logic capture;     // latch imem_rdata/fetch_addr into inst/pc
  logic accept;      // controller took the held instruction
  logic load_next;   // adopt next_pc as the fetch address
  logic load_flush;  // adopt flush_pc as the fetch address
  logic timer_clr;
  logic timer_en;
  logic timer_expired;

  // The timer only runs while waiting for an ack; leaving REQ or any flush
  // zeroes it, so each entry into REQ starts a fresh wait window.
  assign timer_clr = (state_q != REQ) || flush;
  assign timer_en  = (state_q == REQ) && !imem_ack && !flush;

  z_fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // Next-state and datapath-enable decode; flush overrides every other event.
  // NOTE: every signal driven here gets a default first so no path through the
  // block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state_q;
    capture    = 1'b0;
    accept     = 1'b0;
    load_next  = 1'b0;
    load_flush = 1'b0;
    if (flush) begin
      if (is_misaligned(flush_pc)) begin
        state_next = FAULT;
      end else begin
        state_next = IDLE;
        load_flush = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: state_next = REQ;
        REQ: begin
          if (imem_ack) begin
            capture    = 1'b1;
            state_next = HOLD;
          end else if (timer_expired) begin
            state_next = FAULT;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            accept = 1'b1;
            if (is_misaligned(next_pc)) begin
              state_next = FAULT;
            end else begin
              load_next  = 1'b1;
              state_next = REQ;
            end
          end
        end
        FAULT: state_next = FAULT;
        default: state_next = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Fetch address: redirected by flush or by the controller's next_pc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr_q <= RESET_PC;
    end else if (load_flush) begin
      fetch_addr_q <= flush_pc;
    end else if (load_next) begin
      fetch_addr_q <= next_pc;
    end
  end

  // Instruction/PC capture on an accepted memory response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q <= '0;
      pc_q   <= '0;
    end else if (capture) begin
      inst_q <= imem_rdata;
      pc_q   <= fetch_addr_q;
    end
  end

  // Retired-fetch counter; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'd0;
    end else if (accept) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = fetch_addr_q;
  assign inst_valid  = (state_q == HOLD);
  assign fault       = (state_q == FAULT);
  assign inst        = inst_q;
  assign pc          = pc_q;
  assign fetch_count = count_q;

endmodule
